// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter that shares one line-wide memory
// request/response port between NUM_REQ requesters. One transaction is
// outstanding at a time: IDLE (arbitrate) -> ISSUE (present to memory)
// -> WAIT (await completion, route response to owner).
//
// Ports:
//   clock, reset                     rising-edge clock, synchronous active-high reset
//   req_valid/req_ready              per-requester handshake (req_ready combinational)
//   req_write/req_addr/req_wdata     per-requester payload, flattened per requester
//   rsp_valid/rsp_rdata/rsp_error    one-cycle completion pulse to owner, shared data
//   mem_req_valid/ready/write/addr/wdata   request channel to memory
//   mem_rsp_valid/mem_rsp_rdata      completion from memory
//   busy, grant_id                   status: not IDLE, owner of current transaction
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a WAIT watchdog that
// completes the transaction with rsp_error=1 after TIMEOUT_CYCLES cycles.
module mem_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINE_WIDTH     = 128,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*LINE_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [LINE_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_error,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic                             mem_req_write,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    output logic [LINE_WIDTH-1:0]            mem_req_wdata,
    input  logic                             mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0]            mem_rsp_rdata,
    output logic                             busy,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    // Reject unsupported configurations at elaboration time.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("mem_bus_arbiter: unsupported parameter configuration");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [ID_W-1:0]       rr_ptr, rr_ptr_next;
    logic [ID_W-1:0]       cand, win_id;
    logic                  win_found;

    logic                  mem_req_valid_next, mem_req_write_next;
    logic [ADDR_WIDTH-1:0] mem_req_addr_next;
    logic [LINE_WIDTH-1:0] mem_req_wdata_next, rsp_rdata_next;
    logic [NUM_REQ-1:0]    rsp_valid_next;
    logic                  rsp_error_next, busy_next;
    logic [ID_W-1:0]       grant_id_next, owner_inc;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    logic [CNT_W-1:0]      wait_cnt, wait_cnt_next;
`endif

    // Rotating-priority search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin : p_search
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Accept only in IDLE, only the winner.
    always_comb begin : p_ready
        req_ready = '0;
        if (state == ST_IDLE && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // Pointer moves past the owner on completion.
    assign owner_inc = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // Next-state and next-output logic.
    always_comb begin : p_next
        state_next         = state;
        rr_ptr_next        = rr_ptr;
        mem_req_valid_next = mem_req_valid;
        mem_req_write_next = mem_req_write;
        mem_req_addr_next  = mem_req_addr;
        mem_req_wdata_next = mem_req_wdata;
        grant_id_next      = grant_id;
        rsp_valid_next     = '0;
        rsp_rdata_next     = rsp_rdata;
        rsp_error_next     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_next      = wait_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    state_next         = ST_ISSUE;
                    mem_req_valid_next = 1'b1;
                    mem_req_write_next = req_write[win_id];
                    mem_req_addr_next  = req_addr[32'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_req_wdata_next = req_wdata[32'(win_id)*LINE_WIDTH +: LINE_WIDTH];
                    grant_id_next      = win_id;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    state_next         = ST_WAIT;
                    mem_req_valid_next = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt_next      = '0;
`endif
                end
            end
            ST_WAIT: begin
                // A real response always beats a coincident timeout.
                if (mem_rsp_valid) begin
                    state_next               = ST_IDLE;
                    rr_ptr_next              = owner_inc;
                    rsp_valid_next[grant_id] = 1'b1;
                    rsp_rdata_next           = mem_rsp_rdata;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next               = ST_IDLE;
                    rr_ptr_next              = owner_inc;
                    rsp_valid_next[grant_id] = 1'b1;
                    rsp_rdata_next           = '0;
                    rsp_error_next           = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin : p_regs
        if (reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            grant_id      <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_error     <= 1'b0;
            busy          <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            state         <= state_next;
            rr_ptr        <= rr_ptr_next;
            mem_req_valid <= mem_req_valid_next;
            mem_req_write <= mem_req_write_next;
            mem_req_addr  <= mem_req_addr_next;
            mem_req_wdata <= mem_req_wdata_next;
            grant_id      <= grant_id_next;
            rsp_valid     <= rsp_valid_next;
            rsp_rdata     <= rsp_rdata_next;
            rsp_error     <= rsp_error_next;
            busy          <= busy_next;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt      <= wait_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (NUM_REQ=2, 32-bit
// addresses, 128-bit lines, TIMEOUT_CYCLES=10). The bench plays memory.
module tb_mem_bus_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   req_valid, req_ready, req_write, rsp_valid;
    logic [31:0]  addr0, addr1;
    logic [127:0] wdata0, wdata1;
    logic [63:0]  req_addr;
    logic [255:0] req_wdata;
    logic [127:0] rsp_rdata, mem_req_wdata, mem_rsp_rdata;
    logic         rsp_error, mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid, busy;
    logic [0:0]   grant_id;

    int total = 0;
    int fails = 0;

    assign req_addr  = {addr1, addr0};
    assign req_wdata = {wdata1, wdata0};

    always #5 clock = ~clock;

    mem_bus_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(32), .LINE_WIDTH(128), .TIMEOUT_CYCLES(10)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction with the expected winner; memory accepts at once and
    // answers two cycles after acceptance.
    task automatic run_txn(input int id, input logic wr, input logic [31:0] addr,
                           input logic [127:0] wd, input logic [127:0] rd, input bit drop);
        logic [1:0] onehot;
        onehot = 2'b01 << id;
        #1;
        chk("ready_idle", 128'(req_ready), 128'(onehot));
        tick();
        chk("issue_valid", 128'(mem_req_valid), 128'(1));
        chk("issue_addr", 128'(mem_req_addr), 128'(addr));
        chk("issue_write", 128'(mem_req_write), 128'(wr));
        chk("issue_wdata", mem_req_wdata, wd);
        chk("issue_grant", 128'(grant_id), 128'(id));
        chk("issue_busy", 128'(busy), 128'(1));
        if (drop) req_valid[id] = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("wait_memvalid", 128'(mem_req_valid), 128'(0));
        chk("wait_ready", 128'(req_ready), 128'(0));
        tick();
        chk("wait_norsp", 128'(rsp_valid), 128'(0));
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rd;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rsp_valid", 128'(rsp_valid), 128'(onehot));
        chk("rsp_error", 128'(rsp_error), 128'(0));
        chk("rsp_busy", 128'(busy), 128'(0));
        if (!wr) chk("rsp_rdata", rsp_rdata, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset = 1'b1;
        req_valid = '0; req_write = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        tick();
        tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_memvalid", 128'(mem_req_valid), 128'(0));
        chk("rst_memaddr", 128'(mem_req_addr), 128'(0));
        chk("rst_rspvalid", 128'(rsp_valid), 128'(0));
        chk("rst_rdata", rsp_rdata, 128'(0));
        chk("rst_grant", 128'(grant_id), 128'(0));
        chk("rst_error", 128'(rsp_error), 128'(0));
        reset = 1'b0;

        // Single read by requester 0.
        addr0 = 32'h1000;
        req_valid = 2'b01;
        run_txn(0, 1'b0, 32'h1000, 128'h0, 128'h000A, 1'b1);
        tick();
        chk("rsp_pulse_end", 128'(rsp_valid), 128'(0));

        // Requester 1 writes then reads back 0x1040.
        addr1 = 32'h1040; wdata1 = 128'h0014;
        req_write = 2'b10; req_valid = 2'b10;
        run_txn(1, 1'b1, 32'h1040, 128'h0014, 128'hDEAD, 1'b1);
        req_write = 2'b00; req_valid = 2'b10;
        run_txn(1, 1'b0, 32'h1040, 128'h0014, 128'h0014, 1'b1);

        // Both requesters held: grants alternate 0,1,0,1.
        addr0 = 32'h2000; addr1 = 32'h3000; wdata0 = 128'h0;
        req_valid = 2'b11;
        run_txn(0, 1'b0, 32'h2000, 128'h0, 128'h1111, 1'b0);
        run_txn(1, 1'b0, 32'h3000, 128'h0014, 128'h2222, 1'b0);
        run_txn(0, 1'b0, 32'h2000, 128'h0, 128'h3333, 1'b0);
        run_txn(1, 1'b0, 32'h3000, 128'h0014, 128'h4444, 1'b0);
        req_valid = 2'b00;

        // Memory backpressure for 5 cycles; stray mem_rsp_valid in ISSUE ignored.
        addr0 = 32'h4000; wdata0 = 128'h0055; req_write = 2'b01;
        req_valid = 2'b01;
        #1;
        chk("bp_ready_idle", 128'(req_ready), 128'(2'b01));
        tick();
        req_valid = 2'b11;
        mem_rsp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 128'(mem_req_valid), 128'(1));
            chk("bp_addr", 128'(mem_req_addr), 128'(32'h4000));
            chk("bp_write", 128'(mem_req_write), 128'(1));
            chk("bp_wdata", mem_req_wdata, 128'h0055);
            chk("bp_ready", 128'(req_ready), 128'(0));
            chk("bp_norsp", 128'(rsp_valid), 128'(0));
            tick();
        end
        mem_rsp_valid = 1'b0;
        req_valid = 2'b00;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("bp_accepted", 128'(mem_req_valid), 128'(0));
        chk("bp_wait_busy", 128'(busy), 128'(1));

        // Reset in WAIT abandons the transaction; late response is ignored.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_busy", 128'(busy), 128'(0));
        chk("rstw_rsp", 128'(rsp_valid), 128'(0));
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 128'hBAD;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rstw_stale_rsp", 128'(rsp_valid), 128'(0));
        chk("rstw_stale_busy", 128'(busy), 128'(0));
        req_write = 2'b00;
        req_valid = 2'b11;
        run_txn(0, 1'b0, 32'h4000, 128'h0055, 128'h5555, 1'b1);
        req_valid = 2'b00;

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: error completion 10 cycles after entering WAIT.
        addr0 = 32'h5000;
        tick();
        req_valid = 2'b01;
        #1;
        chk("to_ready", 128'(req_ready), 128'(2'b01));
        tick();
        req_valid = 2'b00;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 1; i < 10; i++) begin
            tick();
            chk("to_pending", 128'(rsp_valid), 128'(0));
            chk("to_busy", 128'(busy), 128'(1));
        end
        tick();
        chk("to_rsp", 128'(rsp_valid), 128'(2'b01));
        chk("to_error", 128'(rsp_error), 128'(1));
        chk("to_rdata", rsp_rdata, 128'(0));
        chk("to_idle", 128'(busy), 128'(0));
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter sharing the single line-wide `MEM_core` request/response port between `NUM_REQ` requesters, e.g. CPU instruction fetch, CPU data port and an offload/DMA engine. It sits between the requesters and the memory bus. It accepts one line transaction at a time, forwards it to memory, waits for completion and routes the response back to the owner. Grant priority rotates so every requester is eventually served.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `ADDR_WIDTH`, default 32: byte address width.
- `LINE_WIDTH`, default 128: data line width in bits (16-byte lines).
- `TIMEOUT_CYCLES`, default 255: watchdog limit in WAIT. Used only with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `clock` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: per-requester accept. One-hot or zero.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*ADDR_WIDTH: flattened. Requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata` in NUM_REQ*LINE_WIDTH: flattened write lines.
- `rsp_valid` out NUM_REQ: one-cycle completion pulse to the owner.
- `rsp_rdata` out LINE_WIDTH: read line, shared by all requesters. Qualified by `rsp_valid`.
- `rsp_error` out 1: completion was a timeout. Qualified by `rsp_valid`.
- `mem_req_valid` out 1: request to memory.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_write` out 1, `mem_req_addr` out ADDR_WIDTH, `mem_req_wdata` out LINE_WIDTH: request payload to memory.
- `mem_rsp_valid` in 1: memory completion. Acknowledges a write or returns read data.
- `mem_rsp_rdata` in LINE_WIDTH: read data from memory.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out $clog2(NUM_REQ): owner of the current transaction.

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT. Exactly one transaction is outstanding at a time.
- **IDLE:**
  - The winner is the first requester with `req_valid` set, searching upward from `rr_ptr` with wrap-around.
  - `req_ready[winner]=1`. All other ready bits are 0. With no valid request, all ready bits are 0.
  - On the handshake, latch write, addr, wdata and the owner id, then go to ISSUE.
- **ISSUE:**
  - `mem_req_valid=1`, driven with the latched payload, which stays stable until accepted.
  - On `mem_req_ready`, go to WAIT.
- **WAIT:**
  - On `mem_rsp_valid`, register `mem_rsp_rdata` into `rsp_rdata`.
  - Pulse `rsp_valid[owner]` in the next cycle.
  - Set `rr_ptr = (owner+1) mod NUM_REQ` and go to IDLE.
- Writes also wait for `mem_rsp_valid`; `rsp_rdata` is don't-care for writes.
- `mem_rsp_valid` is ignored in IDLE and ISSUE.
- `rr_ptr` changes only on completion. A requester that drops `req_valid` before being granted is simply skipped.
- Requester-side contract: `req_*` must be stable while `req_valid=1` and not yet accepted.

## Timing
- All outputs are registered except `req_ready`, which is combinational from `req_valid`, `rr_ptr` and the state.
- **Reset values:**
  - State is IDLE and `rr_ptr` is 0.
  - `mem_req_valid`, `mem_req_write`, `mem_req_addr`, `mem_req_wdata`, `rsp_valid`, `rsp_rdata`, `rsp_error`, `busy` and `grant_id` are all 0.
- **Latency:**
  - Handshake in cycle N gives `mem_req_valid` high in cycle N+1.
  - `mem_rsp_valid` in cycle M gives `rsp_valid` in cycle M+1, and the FSM is in IDLE in M+1.
  - A new grant is possible in M+1, so back-to-back transactions are 3 cycles apart with zero-latency memory.
- **Reset mid-transaction:** the transaction is abandoned with no `rsp_valid`. A stale `mem_rsp_valid` arriving after reset is ignored because the FSM is in IDLE.
- `mem_rsp_valid` coinciding with a new `req_valid` in WAIT: complete first. The new request is arbitrated in IDLE, one cycle later.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - On reaching `TIMEOUT_CYCLES` without `mem_rsp_valid`, pulse `rsp_valid[owner]` with `rsp_error=1` and `rsp_rdata=0`.
  - Advance `rr_ptr` and return to IDLE.
  - If `mem_rsp_valid` arrives in the same cycle, the normal response wins with `rsp_error=0`.
- `MEM_ARB_TIMEOUT_EN` undefined: no counter, `rsp_error` is tied to 0, and WAIT lasts indefinitely.

## Test plan
- **Single read:** requester 0 reads addr 0x1000, and memory returns 0x…000A with a 2-cycle delay → `mem_req_addr=0x1000`, then `rsp_valid[0]` one cycle after `mem_rsp_valid`, with `rsp_rdata=0x…000A` and `rsp_error=0`.
- **Round-robin:** both requesters hold `req_valid` continuously for 4 transactions → grants go 0,1,0,1, and `grant_id` matches each time.
- **Write then read:** requester 1 writes line 0x…0014 to 0x1040, then reads 0x1040 → the write completes via `mem_rsp_valid`, and the read returns 0x…0014.
- **Memory backpressure:** `mem_req_ready` is held low for 5 cycles → `mem_req_valid` and the payload stay stable, and neither `req_ready` rises.
- **Reset mid-WAIT:** assert `reset` for 1 cycle during WAIT, then pulse `mem_rsp_valid` → no `rsp_valid`, `busy=0`, and the next grant goes to requester 0.
- **Timeout (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=10):** memory never responds → `rsp_valid[owner]` with `rsp_error=1` exactly 10 cycles after entering WAIT, and the FSM is back in IDLE.
